neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Sequential neuron datapath that sits directly downstream of the selection_input table.
- Drives the table's 16-bit index and consumes its 8-bit input and weight outputs.
- Computes a signed multiply-accumulate over a programmable index window, then applies ReLU with clamp.
- Reports the result through a start/busy/done handshake to the network controller.

Parameters:
- IDX_W, 16, width of index, base_index and count.
- DATA_W, 8, width of in_data and weight_data (signed two's complement).
- ACC_W, 24, signed accumulator width (must be at least 2*DATA_W).
- SHIFT, 0, arithmetic right shift applied to the accumulator before activation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- base_index  input  IDX_W  first table index, sampled with start
- count  input  IDX_W  number of pairs to accumulate, sampled with start
- index  output  IDX_W  registered index to the selection table
- in_data  input  DATA_W  table input value for the current index (combinational from index)
- weight_data  input  DATA_W  table weight value for the current index
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results are valid
- acc_out  output  ACC_W  signed accumulated sum, held until the next done
- act_out  output  8  unsigned ReLU/clamped activation, held
- overflow  output  1  sticky saturation flag for the current operation

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; index, acc, product register and prod_valid all 0.
  - busy=0, done=0, acc_out=0, act_out=0, overflow=0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1 and count!=0:
  - index<=base_index, remaining<=count, acc<=0, overflow<=0, busy<=1.
  - Next state RUN.
- IDLE, start=1 and count==0:
  - acc<=0, overflow<=0, busy<=1, next state DONE.
- RUN, at each edge:
  - prod<=signed(in_data)*signed(weight_data), 2*DATA_W bits; prod_valid<=1.
  - index<=index+1, wrapping modulo 2^IDX_W; remaining<=remaining-1.
  - If remaining==1, next state DRAIN.
- DRAIN, at the edge:
  - Accumulates the last product; prod_valid<=0; next state DONE.
- Accumulate rule, applied at every edge where prod_valid=1:
  - acc<=acc+sign-extended prod, saturating at +(2^(ACC_W-1)-1) and -2^(ACC_W-1).
  - On saturation overflow<=1 (sticky until the next accepted start).
- DONE, at the edge:
  - acc_out<=acc.
  - act_out<= 0 if acc<=0; otherwise min(acc>>>SHIFT, 255).
  - done<=1 for exactly one cycle; busy<=0; next state IDLE.
- Latency: with the start edge numbered 0, done is high in the cycle after edge count+2. For count==0, done is high in the cycle after edge 1.
- Selection stage timing: pair data for index k is sampled at the edge after index=k is presented.
- After a run, index holds base_index+count (mod 2^IDX_W) until the next accepted start.
- start while busy is ignored, and base_index/count are not resampled.
- start asserted in the same cycle done is high is ignored. It is accepted only in IDLE, one cycle later.
- acc_out, act_out and overflow hold their values between operations. Only overflow is cleared on an accepted start.

Test Plan:
1. Table {1:(16,16),2:(0,0),3:(1,1)}; base=1, count=3:
   - index sequence 1,2,3.
   - done after edge 5; acc_out=257; act_out=255; overflow=0.
2. Pairs (-3,5),(2,4); count=2 -> done after edge 4; acc_out=-7 (24'hFFFFF9); act_out=0.
3. count=0 -> done after edge 1; acc_out=0; act_out=0; busy high only for 1 cycle.
4. 600 pairs of (127,127):
   - acc saturates at the 521st product.
   - acc_out=8388607, overflow=1, act_out=255.
   - The next run with small values shows overflow cleared.
5. base=16'hFFFE, count=3 -> index FFFE, FFFF, 0000. Then start pulsed mid-run is ignored, and exactly one done is seen.
6. rst asserted at edge 2 of a count=5 run:
   - All outputs return to 0 and no done pulse occurs.
   - A fresh start afterwards completes correctly.

Source files
------------

// File: rtl/neuron_mac.sv
// Signed multiply-accumulate over a window of selection-table entries, followed by
// a ReLU with clamp to 8 bits. Handshake is start / busy / done.
module neuron_mac #(
  parameter int IDX_W  = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  base_index,
  input  logic [IDX_W-1:0]  count,
  output logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] weight_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out,
  output logic [7:0]        act_out,
  output logic              overflow
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          index_q, index_d;
  logic [IDX_W-1:0]          remaining_q, remaining_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic                      prod_valid_q, prod_valid_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic [7:0]                act_q, act_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      overflow_q, overflow_d;

  logic signed [ACC_W:0]     sum;
  logic signed [ACC_W-1:0]   shifted;
  logic                      accept;

  // One guard bit: the top two sum bits disagreeing means the add left range.
  assign sum     = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W+1-PROD_W){prod_q[PROD_W-1]}}, prod_q};
  assign shifted = acc_q >>> SHIFT;
  // A start in the done cycle is dropped; the FSM is only really idle afterwards.
  assign accept  = (state_q == S_IDLE) && start && !done_q;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    remaining_d  = remaining_q;
    prod_d       = prod_q;
    prod_valid_d = prod_valid_q;
    acc_d        = acc_q;
    acc_out_d    = acc_out_q;
    act_d        = act_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;

    if (prod_valid_q) begin
      if (sum[ACC_W:ACC_W-1] == 2'b01) begin
        acc_d      = ACC_MAX;
        overflow_d = 1'b1;
      end else if (sum[ACC_W:ACC_W-1] == 2'b10) begin
        acc_d      = ACC_MIN;
        overflow_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d      = '0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          if (count != '0) begin
            index_d     = base_index;
            remaining_d = count;
            state_d     = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        prod_d       = $signed(in_data) * $signed(weight_data);
        prod_valid_d = 1'b1;
        index_d      = index_q + IDX_ONE;
        remaining_d  = remaining_q - IDX_ONE;
        if (remaining_q == IDX_ONE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        prod_valid_d = 1'b0;
        state_d      = S_DONE;
      end
      S_DONE: begin
        acc_out_d = acc_q;
        if (acc_q[ACC_W-1] || (acc_q == '0)) act_d = 8'd0;
        else if (|shifted[ACC_W-1:8])        act_d = 8'hFF;
        else                                 act_d = shifted[7:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      remaining_q  <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      acc_q        <= '0;
      acc_out_q    <= '0;
      act_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      remaining_q  <= remaining_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
      acc_q        <= acc_d;
      acc_out_q    <= acc_out_d;
      act_q        <= act_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign index    = index_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign acc_out  = acc_out_q;
  assign act_out  = act_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: a 16-entry table model indexed by index[3:0]
// feeds the DUT; expected results are hand-computed per scenario.
module tb_neuron_mac;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] base_index, count, index;
  logic [7:0]  in_data, weight_data;
  logic        busy, done, overflow;
  logic [23:0] acc_out;
  logic [7:0]  act_out;

  logic [7:0]  t_in [16];
  logic [7:0]  t_w  [16];
  logic [15:0] idx_log [64];
  int          lat;
  int          n_cmp = 0;
  int          n_bad = 0;

  neuron_mac dut (
    .clk(clk), .rst(rst), .start(start), .base_index(base_index), .count(count),
    .index(index), .in_data(in_data), .weight_data(weight_data), .busy(busy),
    .done(done), .acc_out(acc_out), .act_out(act_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  assign in_data     = t_in[index[3:0]];
  assign weight_data = t_w[index[3:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_tbl();
    for (int i = 0; i < 16; i++) begin
      t_in[i] = 8'd0;
      t_w[i]  = 8'd0;
    end
  endtask

  // Pulse start at edge 0, then count edges until done; mid>0 pulses a bogus start before that edge.
  task automatic do_run(input logic [15:0] b, input logic [15:0] c, input int mid);
    int n;
    base_index = b;
    count      = c;
    start      = 1'b1;
    step();
    start      = 1'b0;
    idx_log[0] = index;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    n = 0;
    while (n < 2000 && !done) begin
      if (n + 1 == mid) begin
        start = 1'b1; base_index = 16'h0000; count = 16'd7;
      end
      step();
      start = 1'b0;
      n++;
      if (n < 64) idx_log[n] = index;
    end
    lat = n;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic post_quiet();
    int extra = 0;
    repeat (4) begin
      step();
      if (done) extra++;
    end
    chk("no_extra_done", extra, 0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_index = '0; count = '0;
    clr_tbl();
    step(); step();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_acc", {8'd0, acc_out}, 0);
    chk("rst_act", {24'd0, act_out}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_index", {16'd0, index}, 0);
    rst = 1'b0;
    step();

    // 1: 256 + 0 + 1 = 257, clamps to 255
    t_in[1] = 8'd16; t_w[1] = 8'd16;
    t_in[3] = 8'd1;  t_w[3] = 8'd1;
    do_run(16'd1, 16'd3, -1);
    chk("t1_lat", lat, 5);
    chk("t1_idx0", {16'd0, idx_log[0]}, 1);
    chk("t1_idx1", {16'd0, idx_log[1]}, 2);
    chk("t1_idx2", {16'd0, idx_log[2]}, 3);
    chk("t1_acc", {8'd0, acc_out}, 257);
    chk("t1_act", {24'd0, act_out}, 255);
    chk("t1_ovf", {31'd0, overflow}, 0);
    chk("t1_index_hold", {16'd0, index}, 4);
    // start during the done cycle must be dropped
    start = 1'b1; base_index = 16'd3; count = 16'd1;
    step();
    start = 1'b0;
    chk("t1_start_in_done_busy", {31'd0, busy}, 0);
    post_quiet();

    // 2: -15 + 8 = -7
    t_in[8] = 8'hFD; t_w[8] = 8'd5;
    t_in[9] = 8'd2;  t_w[9] = 8'd4;
    do_run(16'd8, 16'd2, -1);
    chk("t2_lat", lat, 4);
    chk("t2_acc", {8'd0, acc_out}, 32'h00FF_FFF9);
    chk("t2_act", {24'd0, act_out}, 0);
    post_quiet();

    // 3: empty window
    do_run(16'd5, 16'd0, -1);
    chk("t3_lat", lat, 1);
    chk("t3_acc", {8'd0, acc_out}, 0);
    chk("t3_act", {24'd0, act_out}, 0);
    post_quiet();

    // 4: 600 x 16129 saturates on product 521
    for (int i = 0; i < 16; i++) begin
      t_in[i] = 8'd127; t_w[i] = 8'd127;
    end
    do_run(16'd0, 16'd600, -1);
    chk("t4_lat", lat, 602);
    chk("t4_acc", {8'd0, acc_out}, 8388607);
    chk("t4_act", {24'd0, act_out}, 255);
    chk("t4_ovf", {31'd0, overflow}, 1);
    chk("t4_index_hold", {16'd0, index}, 32'h0258);
    post_quiet();
    chk("t4_ovf_hold", {31'd0, overflow}, 1);
    clr_tbl();
    t_in[5] = 8'd3; t_w[5] = 8'd4;
    do_run(16'd5, 16'd1, -1);
    chk("t4b_lat", lat, 3);
    chk("t4b_acc", {8'd0, acc_out}, 12);
    chk("t4b_act", {24'd0, act_out}, 12);
    chk("t4b_ovf", {31'd0, overflow}, 0);
    post_quiet();

    // 5: index wrap, 6 - 5 + 16 = 17, with an ignored start mid-run
    t_in[14] = 8'd2;  t_w[14] = 8'd3;
    t_in[15] = 8'hFF; t_w[15] = 8'd5;
    t_in[0]  = 8'd4;  t_w[0]  = 8'd4;
    do_run(16'hFFFE, 16'd3, 2);
    chk("t5_lat", lat, 5);
    chk("t5_idx0", {16'd0, idx_log[0]}, 32'hFFFE);
    chk("t5_idx1", {16'd0, idx_log[1]}, 32'hFFFF);
    chk("t5_idx2", {16'd0, idx_log[2]}, 0);
    chk("t5_acc", {8'd0, acc_out}, 17);
    chk("t5_act", {24'd0, act_out}, 17);
    chk("t5_index_hold", {16'd0, index}, 1);
    post_quiet();

    // 6: reset at edge 2 aborts the run
    base_index = 16'd1; count = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_done", {31'd0, done}, 0);
    chk("t6_acc", {8'd0, acc_out}, 0);
    chk("t6_act", {24'd0, act_out}, 0);
    chk("t6_ovf", {31'd0, overflow}, 0);
    chk("t6_index", {16'd0, index}, 0);
    post_quiet();
    t_in[8] = 8'hFD; t_w[8] = 8'd5;
    t_in[9] = 8'd2;  t_w[9] = 8'd4;
    do_run(16'd8, 16'd2, -1);
    chk("t6b_lat", lat, 4);
    chk("t6b_acc", {8'd0, acc_out}, 32'h00FF_FFF9);
    chk("t6b_act", {24'd0, act_out}, 0);
    post_quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
